alu_muldiv_seq: RTL

- Parametrised, multi-cycle multiply/divide unit; the next generation of the CPU's ALU MUL/DIV path.
- Executes signed or unsigned N×N multiply (2N-bit product) and N/N divide (quotient and remainder).
- Runs one bit per cycle under a start/busy/finished handshake, with divide-by-zero and signed-overflow detection.
- Sits beside the ALU; the control unit stalls on busy and samples results on finished.

---
 rtl/alu_muldiv_seq.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle multiply/divide unit that sits beside the ALU.
//   Signed or unsigned N x N multiply (2N-bit product) and N / N divide
//   (quotient + remainder). One bit is processed per cycle under a
//   start/busy/finished handshake.
//
// Ports:
//   CLK       clock, rising edge
//   rst       asynchronous, active-low reset
//   a, b      multiplicand/dividend, multiplier/divisor (N bits)
//   opcode    ALU opcode; only MUL (3) and DIV (4) are accepted
//   uns       1 = unsigned, 0 = signed two's complement
//   start     request, sampled only while idle
//   busy      high in every state except IDLE
//   finished  one-cycle pulse while results are valid
//   result    product low word / quotient
//   high      product high word / remainder
//   flags     [0] ZERO, [1] DIVZ, [2] OVERFLOW, [3] POSITIVE
//
// Build option:
//   MULDIV_FAST_MUL_EN  when defined, MUL uses a single-cycle combinational
//                       multiplier in PREP (PREP -> FIX -> DONE). DIV is
//                       always iterative.
module alu_muldiv_seq #(
    parameter int N            = 32,
    parameter int ALU_OP_COUNT = 4,
    parameter int FLAGS_COUNT  = 4
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic [N-1:0]            a,
    input  logic [N-1:0]            b,
    input  logic [ALU_OP_COUNT-1:0] opcode,
    input  logic                    uns,
    input  logic                    start,
    output logic                    busy,
    output logic                    finished,
    output logic [N-1:0]            result,
    output logic [N-1:0]            high,
    output logic [FLAGS_COUNT-1:0]  flags
);

    localparam logic [ALU_OP_COUNT-1:0] OP_MUL = ALU_OP_COUNT'(3);
    localparam logic [ALU_OP_COUNT-1:0] OP_DIV = ALU_OP_COUNT'(4);
    localparam int                      CW     = $clog2(N + 1);

    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

    state_t           state;
    logic             is_div;
    logic             uns_q;
    logic             sgn_a;
    logic             sgn_b;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;      // raw divisor/multiplier, magnitude after PREP
    logic [2*N-1:0]   acc;      // MUL: {partial product, multiplier}; DIV: quotient in low word
    logic [N-1:0]     rem;
    logic [CW-1:0]    cnt;

    logic [N-1:0]     abs_a;
    logic [N-1:0]     abs_b;
    logic [N:0]       mul_sum;
    logic [N:0]       div_shift;
    logic [N:0]       div_diff;
    logic             neg;
    logic [2*N-1:0]   prod_fix;
    logic [N-1:0]     quot_fix;
    logic [N-1:0]     rem_fix;
    logic [N-1:0]     fix_res;
    logic [N-1:0]     fix_high;
    logic [FLAGS_COUNT-1:0] fix_flags;
    logic             divz;
    logic             sovf;
    logic [FLAGS_COUNT-1:0] divz_flags;
    logic [FLAGS_COUNT-1:0] sovf_flags;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*N-1:0]   fast_prod;
`endif

    always_comb begin
        abs_a = (!uns_q && a_q[N-1]) ? -a_q : a_q;
        abs_b = (!uns_q && b_q[N-1]) ? -b_q : b_q;

        mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, b_q} : '0);
        div_shift = {rem, acc[N-1]};
        div_diff  = div_shift - {1'b0, b_q};

        neg      = !uns_q && (sgn_a ^ sgn_b);
        prod_fix = neg ? -acc : acc;
        quot_fix = neg ? -acc[N-1:0] : acc[N-1:0];
        // remainder follows the dividend's sign (truncating division)
        rem_fix  = (!uns_q && sgn_a) ? -rem : rem;

        fix_flags = '0;
        if (is_div) begin
            fix_res      = quot_fix;
            fix_high     = rem_fix;
            fix_flags[0] = (quot_fix == '0);
            fix_flags[3] = uns_q | ~quot_fix[N-1];
        end else begin
            fix_res      = prod_fix[N-1:0];
            fix_high     = prod_fix[2*N-1:N];
            fix_flags[0] = (prod_fix == '0);
            fix_flags[2] = !uns_q && (fix_high != {N{fix_res[N-1]}});
            fix_flags[3] = uns_q | ~fix_high[N-1];
        end

        divz = is_div && (b_q == '0);
        sovf = is_div && !uns_q && (a_q == {1'b1, {(N-1){1'b0}}}) && (b_q == '1);

        divz_flags    = '0;
        divz_flags[1] = 1'b1;
        divz_flags[3] = uns_q;      // quotient is all-ones: negative when signed
        sovf_flags    = '0;
        sovf_flags[2] = 1'b1;

`ifdef MULDIV_FAST_MUL_EN
        fast_prod = {{N{1'b0}}, abs_a} * {{N{1'b0}}, abs_b};
`endif
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            finished <= 1'b0;
            result   <= '0;
            high     <= '0;
            flags    <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            uns_q    <= 1'b0;
            sgn_a    <= 1'b0;
            sgn_b    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            rem      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    finished <= 1'b0;
                    if (start && (opcode == OP_MUL || opcode == OP_DIV)) begin
                        a_q    <= a;
                        b_q    <= b;
                        is_div <= (opcode == OP_DIV);
                        uns_q  <= uns;
                        busy   <= 1'b1;
                        state  <= PREP;
                    end
                end
                PREP: begin
                    sgn_a <= !uns_q && a_q[N-1];
                    sgn_b <= !uns_q && b_q[N-1];
                    b_q   <= abs_b;
                    if (divz) begin
                        result   <= '1;
                        high     <= a_q;
                        flags    <= divz_flags;
                        finished <= 1'b1;
                        state    <= DONE;
                    end else if (sovf) begin
                        result   <= a_q;
                        high     <= '0;
                        flags    <= sovf_flags;
                        finished <= 1'b1;
                        state    <= DONE;
                    end else begin
                        acc   <= {{N{1'b0}}, abs_a};
                        rem   <= '0;
                        cnt   <= CW'(N);
                        state <= RUN;
`ifdef MULDIV_FAST_MUL_EN
                        // later assignments override the iterative setup for MUL
                        if (!is_div) begin
                            acc   <= fast_prod;
                            cnt   <= '0;
                            state <= FIX;
                        end
`endif
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (is_div) begin
                        // restoring step: keep the difference only if it did not borrow
                        if (!div_diff[N]) begin
                            rem          <= div_diff[N-1:0];
                            acc[N-1:0]   <= {acc[N-2:0], 1'b1};
                        end else begin
                            rem          <= div_shift[N-1:0];
                            acc[N-1:0]   <= {acc[N-2:0], 1'b0};
                        end
                    end else begin
                        acc <= {mul_sum, acc[N-1:1]};
                    end
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result   <= fix_res;
                    high     <= fix_high;
                    flags    <= fix_flags;
                    finished <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    finished <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
